lr_inference_controller: RTL and testbench
==========================================

# lr_inference_controller

Sequencer and configuration front-end for the logistic-regression datapath. Holds the weight/bias store and accepts a feature vector as a valid/ready stream, one feature per cycle. It time-shares a single multiply-accumulate across the features and emits a hard-sigmoid class decision plus the raw linear score. The block sits between the feature source and downstream consumers, and also owns runtime weight updates.

## Interface
- N_FEAT, 2: features per vector (1..14); store holds N_FEAT weights plus 1 bias.
- DATA_W, 32: feature/weight/score width, signed two's complement.
- ADDR_W, 4: config address width; N_FEAT+1 ≤ 2^ADDR_W.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  weight-store write strobe.
- cfg_addr  in  ADDR_W  0..N_FEAT-1 = weight k, N_FEAT = bias.
- cfg_wdata  in  DATA_W  signed write data.
- cfg_ready  out  1  write accepted this cycle when cfg_we & cfg_ready.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  feature beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  signed feature.
- in_last  in  1  marks final feature of the vector.
- out_valid  out  1  result held until accepted.
- out_ready  in  1  downstream accept.
- out_class  out  1  1 if score > 0, else 0.
- out_score  out  DATA_W  signed linear combination.
- out_err  out  1  vector length mismatch on this result.
- frame_count  out  16  completed (accepted) results, wraps at 2^16.

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE: cfg_ready=1; in_ready = ~cfg_we (config write has priority on the same cycle). On a feature handshake: acc <= bias + w[0]*x, k <= 1. Go to ACCUM, or to OUTPUT if in_last is set or N_FEAT=1.
- ACCUM: cfg_ready=0, in_ready=1. Each handshake: acc <= acc + w[k]*x, k <= k+1. Leave for OUTPUT after the beat with k=N_FEAT-1 or the beat with in_last, whichever comes first.
- out_err=1 if in_last arrived with fewer than N_FEAT beats (missing weights contribute 0), or if the N_FEAT-th beat lacked in_last. No beats are dropped or absorbed: the next beat starts a new vector.
- OUTPUT: out_valid=1, in_ready=0, cfg_ready=0. out_score=acc, out_class=(acc>0), out_err latched. On out_ready: frame_count++, go to IDLE.
- Arithmetic: product = low DATA_W bits of the full signed product. Accumulation wraps mod 2^DATA_W. There is no saturation.
- Config writes with cfg_addr > N_FEAT are acknowledged and discarded. Writes while cfg_ready=0 are dropped with no effect.
- Reset values of the store: w[0]=5, w[1]=-3 (if N_FEAT ≥ 2), other weights 0, bias=1.

## Timing
- Reset (synchronous, sampled on clk edge): state=IDLE, acc=0, k=0, out_valid=0, out_class=0, out_score=0, out_err=0, frame_count=0, weight store to the defaults above. Any frame in progress is discarded.
- Throughput: one feature per cycle with no bubbles inside a vector.
- Latency: out_valid rises on the cycle after the final feature handshake.
- Outputs are registered and stable while out_valid=1 && out_ready=0.
- out_ready held high: OUTPUT lasts 1 cycle; in_ready reasserts the following cycle (IDLE). Minimum vector period is N_FEAT+1 cycles.
- A weight write takes effect for any vector whose first beat is accepted on a later cycle.

## Test plan
- Defaults, vector (2,1) with in_last on beat 2 → out_valid 1 cycle after beat 2, out_score=8, out_class=1, out_err=0, frame_count=1.
- Defaults, vector (1,2) → out_score=0, out_class=0. Vector (-1,0) → out_score=-4, out_class=0.
- Config w1=7, bias=-10, then vector (1,1) → out_score=2, class=1. Write to addr 5 → store unchanged. cfg_we with in_valid in IDLE → write taken, in_ready=0 that cycle.
- Backpressure: out_ready low 5 cycles → out_valid, out_score, out_class stable; in_ready=0 throughout; frame_count increments only on the accept edge.
- Length errors: in_last on beat 1 with x=3 → out_score=16, out_err=1. Two beats without in_last → result after beat 2 with out_err=1; next beat starts a new vector.
- Reset asserted mid-ACCUM → next cycle state IDLE, out_valid=0, frame_count=0, weights at defaults. Wrap check: w0=0x40000000, x0=4, x1=0 → out_score=1, class=1.

Source files
------------

// File: rtl/lr_inference_controller.sv
// Logistic-regression sequencer: weight/bias store, streamed feature MAC and
// hard-sigmoid decision. One shared multiply-accumulate, one feature per cycle.
//   state  | meaning
//   IDLE   | accepting config writes or the first feature of a vector
//   ACCUM  | accumulating features 1..N_FEAT-1
//   OUTPUT | result held until out_ready
module lr_inference_controller #(
    parameter int N_FEAT = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_class,
    output logic [DATA_W-1:0] out_score,
    output logic              out_err,
    output logic [15:0]       frame_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    localparam logic signed [DATA_W-1:0] W0_RST   = DATA_W'(5);
    localparam logic signed [DATA_W-1:0] W1_RST   = DATA_W'(-3);
    localparam logic signed [DATA_W-1:0] BIAS_RST = DATA_W'(1);

    state_t                    state;
    logic signed [DATA_W-1:0]  w [N_FEAT];
    logic signed [DATA_W-1:0]  bias;
    logic signed [DATA_W-1:0]  acc;
    logic [ADDR_W-1:0]         k;

    logic [ADDR_W-1:0]         idx;
    logic signed [DATA_W-1:0]  w_sel;
    logic signed [DATA_W-1:0]  prod;
    logic signed [DATA_W-1:0]  acc_next;
    logic                      beat;
    logic                      last_beat;
    logic                      done;
    logic                      err;

    // A config write in IDLE wins over a feature beat on the same cycle.
    assign cfg_ready = (state == IDLE);
    assign in_ready  = ((state == IDLE) && !cfg_we) || (state == ACCUM);
    assign beat      = in_valid && in_ready;

    assign idx       = (state == ACCUM) ? k : '0;
    assign last_beat = (idx == ADDR_W'(N_FEAT - 1));
    assign done      = in_last || last_beat;
    assign err       = in_last ^ last_beat;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (idx == ADDR_W'(i)) w_sel = w[i];
        end
    end

    // Product truncated to DATA_W bits; the sum wraps with no saturation.
    assign prod     = w_sel * $signed(in_data);
    assign acc_next = ((state == IDLE) ? bias : acc) + prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            k           <= '0;
            out_valid   <= 1'b0;
            out_class   <= 1'b0;
            out_score   <= '0;
            out_err     <= 1'b0;
            frame_count <= '0;
            bias        <= BIAS_RST;
            for (int i = 0; i < N_FEAT; i++) begin
                w[i] <= (i == 0) ? W0_RST : ((i == 1) ? W1_RST : '0);
            end
        end else begin
            if (cfg_we && cfg_ready) begin
                for (int i = 0; i < N_FEAT; i++) begin
                    if (cfg_addr == ADDR_W'(i)) w[i] <= cfg_wdata;
                end
                if (cfg_addr == ADDR_W'(N_FEAT)) bias <= cfg_wdata;
            end
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc <= acc_next;
                        k   <= idx + ADDR_W'(1);
                        if (done) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                            out_score <= acc_next;
                            out_class <= (acc_next > 0);
                            out_err   <= err;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lr_inference_controller.sv
// Bench for lr_inference_controller: directed literal cases plus randomized
// traffic checked every cycle against a vector-level reference model.
module tb_lr_inference_controller;

    localparam int N_FEAT = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_ready;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic              out_class;
    logic [DATA_W-1:0] out_score;
    logic              out_err;
    logic [15:0]       frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    lr_inference_controller #(.N_FEAT(N_FEAT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_score(out_score), .out_err(out_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, $signed(act), act, $signed(exp), exp, $time);
        end
    endtask

    // Reference model: vectors are collected as lists of features and scored
    // as bias + sum(w[i]*x[i]) once complete.
    logic signed [DATA_W-1:0] mw [N_FEAT];
    logic signed [DATA_W-1:0] mb;
    logic signed [DATA_W-1:0] xs [$];
    logic                     m_valid;
    logic signed [DATA_W-1:0] m_score;
    logic                     m_class;
    logic                     m_err;
    logic [15:0]              m_fc;
    bit                       started = 0;

    function automatic logic signed [DATA_W-1:0] model_score();
        logic signed [DATA_W-1:0] s;
        logic signed [DATA_W-1:0] p;
        s = mb;
        for (int i = 0; i < xs.size(); i++) begin
            p = mw[i] * xs[i];
            s = s + p;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, !m_valid && !(xs.size() == 0 && cfg_we));
            chk("cfg_ready", cfg_ready, !m_valid && xs.size() == 0);
            chk("out_valid", out_valid, m_valid);
            chk("frame_count", frame_count, m_fc);
            if (m_valid) begin
                chk("out_score", out_score, m_score);
                chk("out_class", out_class, m_class);
                chk("out_err", out_err, m_err);
            end
        end
        if (reset) begin
            for (int i = 0; i < N_FEAT; i++) mw[i] = (i == 0) ? 5 : ((i == 1) ? -3 : 0);
            mb = 1;
            xs.delete();
            m_valid = 0;
            m_score = 0;
            m_class = 0;
            m_err = 0;
            m_fc = 0;
            started = 1;
        end else if (started) begin
            if (m_valid) begin
                if (out_ready) begin
                    m_valid = 0;
                    m_fc = m_fc + 16'd1;
                end
            end else if (xs.size() == 0 && cfg_we) begin
                for (int i = 0; i < N_FEAT; i++) if (int'(cfg_addr) == i) mw[i] = cfg_wdata;
                if (int'(cfg_addr) == N_FEAT) mb = cfg_wdata;
            end else if (in_valid) begin
                xs.push_back(in_data);
                if (in_last || xs.size() == N_FEAT) begin
                    m_score = model_score();
                    m_class = (m_score > 0);
                    m_err = in_last ^ (xs.size() == N_FEAT);
                    m_valid = 1;
                    xs.delete();
                end
            end
        end
    end

    // Drivers start and end just after a rising edge.
    task automatic send_beat(input int x, input logic last);
        logic ok;
        int n = 0;
        in_valid = 1; in_data = x; in_last = last;
        forever begin
            @(negedge clk) ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            if (++n > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL beat_timeout: in_ready low for %0d cycles, required high", n);
                break;
            end
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        logic ok;
        int n = 0;
        cfg_we = 1; cfg_addr = ADDR_W'(addr); cfg_wdata = data;
        forever begin
            @(negedge clk) ok = cfg_ready;
            @(posedge clk); #1;
            if (ok) break;
            if (++n > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL cfg_timeout: cfg_ready low for %0d cycles, required high", n);
                break;
            end
        end
        cfg_we = 0;
    endtask

    task automatic expect_result(input string name, input int score, input logic cls, input logic err);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, 0);
        chk({name, "_score"}, out_score, score);
        chk({name, "_class"}, out_class, cls);
        chk({name, "_err"}, out_err, err);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_score", out_score, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_frame_count", frame_count, 0);
        @(posedge clk); #1;

        send_beat(2, 0); send_beat(1, 1);
        expect_result("v21", 8, 1, 0);
        @(negedge clk) chk("v21_frame_count", frame_count, 1);
        @(posedge clk); #1;
        send_beat(1, 0); send_beat(2, 1);
        expect_result("v12", 0, 0, 0);
        send_beat(-1, 0); send_beat(0, 1);
        expect_result("vm10", -4, 0, 0);

        send_beat(3, 1);
        expect_result("short", 16, 1, 1);
        send_beat(1, 0); send_beat(1, 0);
        expect_result("nolast", 3, 1, 1);
        send_beat(2, 1);
        expect_result("after_nolast", 11, 1, 1);

        out_ready = 0;
        send_beat(3, 0); send_beat(2, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_score", out_score, 10);
            chk("bp_class", out_class, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_frame_count", frame_count, 6);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_accept_count", frame_count, 7);
        chk("bp_accept_valid", out_valid, 0);
        @(posedge clk); #1;

        cfg_write(1, 7); cfg_write(2, -10);
        send_beat(1, 0); send_beat(1, 1);
        expect_result("cfg11", 2, 1, 0);
        cfg_write(5, 99);
        send_beat(1, 0); send_beat(2, 1);
        expect_result("cfg_addr5", 9, 1, 0);

        cfg_we = 1; cfg_addr = 0; cfg_wdata = 2;
        in_valid = 1; in_data = 1; in_last = 0;
        @(negedge clk);
        chk("prio_in_ready", in_ready, 0);
        chk("prio_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_we = 0;
        send_beat(1, 0); send_beat(1, 1);
        expect_result("prio", -1, 0, 0);

        send_beat(4, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", frame_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        send_beat(2, 0); send_beat(1, 1);
        expect_result("midrst_v21", 8, 1, 0);

        cfg_write(0, 32'h4000_0000);
        send_beat(4, 0); send_beat(0, 1);
        expect_result("wrap", 1, 1, 0);

        repeat (3000) begin
            reset     = ($urandom_range(0, 299) == 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = ADDR_W'($urandom_range(0, 5));
            cfg_wdata = $urandom_range(0, 1) ? $urandom() : DATA_W'(int'($urandom_range(0, 20)) - 10);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom_range(0, 3) == 0 ? $urandom() : DATA_W'(int'($urandom_range(0, 40)) - 20);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        reset = 0; cfg_we = 0; in_valid = 0; in_last = 0; out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
